// File: rtl/clb_multi.sv
// rtl/clb_multi.sv - multi-LUT configurable logic block with bit-serial config stream
// Each LUT input comes from a neighbour, io, registered-feedback or constant source.
`timescale 1ns/1ps
module clb_multi #(
   parameter int NUM_LUTS              = 2,
   parameter int LUT_WIDTH             = 3,
   parameter int NUM_NEIGHBOUR_SIGNALS = 8,
   parameter int NUM_IO_SIGNALS        = 4,
   parameter int BITSTREAM_DATA_WIDTH  = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             cfg,
   input  logic                             cfg_tvalid,
   output logic                             cfg_tready,
   input  logic [BITSTREAM_DATA_WIDTH-1:0]  cfg_tdata,
   input  logic                             cfg_tlast,
   output logic                             cfg_ready,
   output logic                             cfg_error,
   input  logic                             run,
   input  logic [NUM_NEIGHBOUR_SIGNALS-1:0] run_in_neighbours,
   input  logic [NUM_IO_SIGNALS-1:0]        run_in_io,
   output logic [NUM_LUTS-1:0]              run_out
);
   localparam int TT       = 2 ** LUT_WIDTH;
   localparam int LUT_BITS = 10 * LUT_WIDTH + TT + 1;
   localparam int PW       = $clog2(LUT_BITS);
   localparam int LCW      = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;

   typedef enum logic [1:0] {S_UNCFG, S_LOAD, S_IDLE, S_RUN} state_t;

   state_t                  r_state, w_next;
   logic [PW-1:0]           r_pos;
   logic [LCW-1:0]          r_lut;
   logic                    r_error;
   logic [1:0]              r_type  [NUM_LUTS][LUT_WIDTH];
   logic [7:0]              r_idx   [NUM_LUTS][LUT_WIDTH];
   logic [TT-1:0]           r_table [NUM_LUTS];
   logic [NUM_LUTS-1:0]     r_ff_en;
   logic [NUM_LUTS-1:0]     r_ff_q;
   logic [NUM_LUTS-1:0][LUT_WIDTH-1:0] w_addr;
   logic [NUM_LUTS-1:0]     w_comb;
   logic                    w_fire, w_final, w_frame_err, w_enter_load;

   assign w_fire       = cfg_tvalid && (r_state == S_LOAD);
   assign w_final      = (r_lut == LCW'(NUM_LUTS - 1)) && (r_pos == PW'(LUT_BITS - 1));
   assign w_frame_err  = w_fire && (cfg_tlast != w_final);
   assign w_enter_load = (r_state != S_LOAD) && (w_next == S_LOAD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_UNCFG;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_UNCFG: if (cfg) w_next = S_LOAD;
         S_LOAD: begin
            if (w_frame_err)                w_next = S_UNCFG;
            else if (w_fire && cfg_tlast)   w_next = S_IDLE;
         end
         S_IDLE: begin
            if (run)      w_next = S_RUN;
            else if (cfg) w_next = S_LOAD;
         end
         S_RUN:   if (!run) w_next = S_IDLE;
         default: w_next = S_UNCFG;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pos   <= '0;
         r_lut   <= '0;
         r_error <= 1'b0;
         r_ff_q  <= '0;
         r_ff_en <= '0;
         for (int l = 0; l < NUM_LUTS; l++) begin
            r_table[l] <= '0;
            for (int i = 0; i < LUT_WIDTH; i++) begin
               r_type[l][i] <= '0;
               r_idx[l][i]  <= '0;
            end
         end
      end else if (w_enter_load) begin
         r_pos   <= '0;
         r_lut   <= '0;
         r_error <= 1'b0;
         r_ff_q  <= '0;
      end else begin
         if (r_state == S_RUN) r_ff_q <= w_comb;
         if (w_fire) begin
            if (w_frame_err) r_error <= 1'b1;
            if (r_pos == PW'(LUT_BITS - 1)) begin
               r_pos <= '0;
               r_lut <= r_lut + 1'b1;
            end else begin
               r_pos <= r_pos + 1'b1;
            end
            // Each stream bit lands directly in its field; position decode is unrolled per LUT.
            for (int l = 0; l < NUM_LUTS; l++) begin
               if (r_lut == LCW'(l)) begin
                  for (int i = 0; i < LUT_WIDTH; i++) begin
                     for (int b = 0; b < 2; b++)
                        if (r_pos == PW'(10 * i + b)) r_type[l][i][b] <= cfg_tdata[0];
                     for (int b = 0; b < 8; b++)
                        if (r_pos == PW'(10 * i + 2 + b)) r_idx[l][i][b] <= cfg_tdata[0];
                  end
                  for (int t = 0; t < TT; t++)
                     if (r_pos == PW'(10 * LUT_WIDTH + t)) r_table[l][t] <= cfg_tdata[0];
                  if (r_pos == PW'(LUT_BITS - 1)) r_ff_en[l] <= cfg_tdata[0];
               end
            end
         end
      end
   end

   // Feedback always reads the registered value, so no combinational loops can form.
   always_comb begin
      w_addr = '0;
      w_comb = '0;
      for (int l = 0; l < NUM_LUTS; l++) begin
         for (int i = 0; i < LUT_WIDTH; i++) begin
            case (r_type[l][i])
               2'd0: for (int k = 0; k < NUM_NEIGHBOUR_SIGNALS; k++)
                        if (r_idx[l][i] == 8'(k)) w_addr[l][i] = run_in_neighbours[k];
               2'd1: for (int k = 0; k < NUM_IO_SIGNALS; k++)
                        if (r_idx[l][i] == 8'(k)) w_addr[l][i] = run_in_io[k];
               2'd2: for (int k = 0; k < NUM_LUTS; k++)
                        if (r_idx[l][i] == 8'(k)) w_addr[l][i] = r_ff_q[k];
               default: w_addr[l][i] = r_idx[l][i][0];
            endcase
         end
         w_comb[l] = r_table[l][w_addr[l]];
      end
   end

   assign cfg_tready = (r_state == S_LOAD);
   assign cfg_ready  = (r_state == S_IDLE) || (r_state == S_RUN);
   assign cfg_error  = r_error;
   assign run_out    = cfg_ready ? ((r_ff_en & r_ff_q) | (~r_ff_en & w_comb)) : '0;
endmodule

// File: tb/tb_clb_multi.sv
// tb/tb_clb_multi.sv - scoreboard bench for clb_multi with a behavioural LUT model
`timescale 1ns/1ps
module tb_clb_multi;
   localparam int NL  = 2;
   localparam int LW  = 3;
   localparam int NN  = 8;
   localparam int NIO = 4;
   localparam int TOT = NL * (10 * LW + (1 << LW) + 1);

   logic           clk = 1'b0;
   logic           rst, cfg, cfg_tvalid, cfg_tlast, run;
   logic [0:0]     cfg_tdata;
   logic           cfg_tready, cfg_ready, cfg_error;
   logic [NN-1:0]  nb;
   logic [NIO-1:0] io;
   logic [NL-1:0]  run_out;

   always #5 clk = ~clk;

   clb_multi #(.NUM_LUTS(NL), .LUT_WIDTH(LW), .NUM_NEIGHBOUR_SIGNALS(NN),
               .NUM_IO_SIGNALS(NIO), .BITSTREAM_DATA_WIDTH(1)) dut (
      .clk(clk), .rst(rst), .cfg(cfg), .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready),
      .cfg_tdata(cfg_tdata), .cfg_tlast(cfg_tlast), .cfg_ready(cfg_ready), .cfg_error(cfg_error),
      .run(run), .run_in_neighbours(nb), .run_in_io(io), .run_out(run_out));

   // reference model: intended configuration plus register contents as plain integers
   int m_type [NL][LW];
   int m_idx  [NL][LW];
   int m_tab  [NL];
   int m_ffen [NL];
   int m_ff;
   bit m_cfgd, m_running;

   typedef struct {int kind; int exp; string name;} chk_t;
   chk_t sb[$];
   chk_t mon_c;
   int   mon_act;
   int   n_cmp = 0;
   int   n_fail = 0;

   function automatic int src(int ty, int ix);
      case (ty)
         0:       return (ix < NN)  ? ((int'(nb) >> ix) & 1) : 0;
         1:       return (ix < NIO) ? ((int'(io) >> ix) & 1) : 0;
         2:       return (ix < NL)  ? ((m_ff >> ix) & 1) : 0;
         default: return ix & 1;
      endcase
   endfunction

   function automatic int comb_all();
      int r, a;
      r = 0;
      for (int l = 0; l < NL; l++) begin
         a = 0;
         for (int i = 0; i < LW; i++) a = a | (src(m_type[l][i], m_idx[l][i]) << i);
         r = r | (((m_tab[l] >> a) & 1) << l);
      end
      return r;
   endfunction

   function automatic int exp_out();
      int c, r;
      if (!m_cfgd) return 0;
      c = comb_all();
      r = 0;
      for (int l = 0; l < NL; l++)
         r = r | ((m_ffen[l] != 0 ? ((m_ff >> l) & 1) : ((c >> l) & 1)) << l);
      return r;
   endfunction

   task automatic push(int kind, int exp, string name);
      chk_t c;
      c.kind = kind;
      c.exp  = exp;
      c.name = name;
      sb.push_back(c);
   endtask

   task automatic chk_out(string name);
      push(0, exp_out(), name);
   endtask

   task automatic chk_status(int rdy, int err, int trdy, string name);
      push(1, rdy,  {name, "_cfg_ready"});
      push(2, err,  {name, "_cfg_error"});
      push(3, trdy, {name, "_cfg_tready"});
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0) begin
         mon_c = sb.pop_front();
         case (mon_c.kind)
            0:       mon_act = int'(run_out);
            1:       mon_act = int'(cfg_ready);
            2:       mon_act = int'(cfg_error);
            default: mon_act = int'(cfg_tready);
         endcase
         n_cmp++;
         if (mon_act != mon_c.exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", mon_c.name, mon_act, mon_c.exp);
         end
      end
   end

   task automatic tick();
      int nxt;
      nxt = m_running ? comb_all() : m_ff;
      @(posedge clk);
      #1;
      m_ff = nxt;
      m_running = m_cfgd && run;
   endtask

   task automatic set_lut(int l, int t0, int i0, int t1, int i1, int t2, int i2, int tab, int ffen);
      m_type[l][0] = t0; m_idx[l][0] = i0;
      m_type[l][1] = t1; m_idx[l][1] = i1;
      m_type[l][2] = t2; m_idx[l][2] = i2;
      m_tab[l] = tab;
      m_ffen[l] = ffen;
   endtask

   task automatic rand_cfg();
      for (int l = 0; l < NL; l++) begin
         for (int i = 0; i < LW; i++) begin
            m_type[l][i] = int'($urandom_range(0, 3));
            m_idx[l][i]  = ($urandom_range(0, 4) == 0) ? 200 : int'($urandom_range(0, 9));
         end
         m_tab[l]  = int'($urandom_range(0, 255));
         m_ffen[l] = int'($urandom_range(0, 1));
      end
   endtask

   task automatic do_load(int nsend, int tlast_at, bit gaps, bit check_end);
      bit bits[$];
      bit ok;
      for (int l = 0; l < NL; l++) begin
         for (int i = 0; i < LW; i++) begin
            for (int b = 0; b < 2; b++) bits.push_back(1'(m_type[l][i] >> b));
            for (int b = 0; b < 8; b++) bits.push_back(1'(m_idx[l][i] >> b));
         end
         for (int t = 0; t < (1 << LW); t++) bits.push_back(1'(m_tab[l] >> t));
         bits.push_back(1'(m_ffen[l]));
      end
      run = 1'b0;
      cfg = 1'b1;
      tick();
      cfg = 1'b0;
      m_cfgd = 1'b0;
      m_ff = 0;
      m_running = 1'b0;
      chk_status(0, 0, 1, "load_start");
      push(0, 0, "load_start_out");
      for (int b = 0; b < nsend; b++) begin
         if (gaps)
            while ($urandom_range(0, 2) == 0) begin
               cfg_tvalid = 1'b0;
               tick();
            end
         cfg_tvalid = 1'b1;
         cfg_tdata[0] = bits[b];
         cfg_tlast = (b == tlast_at);
         tick();
      end
      cfg_tvalid = 1'b0;
      cfg_tlast = 1'b0;
      ok = (nsend == TOT) && (tlast_at == TOT - 1);
      if (ok) m_cfgd = 1'b1;
      if (check_end) chk_status(int'(ok), int'(!ok), 0, "load_end");
   endtask

   task automatic rand_run(int cycles);
      for (int k = 0; k < cycles; k++) begin
         nb  = NN'($urandom);
         io  = NIO'($urandom);
         run = 1'($urandom);
         chk_out("rand_out");
         tick();
      end
      run = 1'b0;
      tick();
      chk_out("rand_idle_out");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int tog_exp[5];
      tog_exp = '{0, 2, 0, 2, 0};
      rst = 1'b1; cfg = 1'b0; cfg_tvalid = 1'b0; cfg_tlast = 1'b0; cfg_tdata = 1'b0;
      run = 1'b0; nb = '0; io = '0;
      m_ff = 0; m_cfgd = 1'b0; m_running = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk_status(0, 0, 0, "reset");
      push(0, 0, "reset_out");
      tick();

      // AND on LUT0, feedback toggle on LUT1
      set_lut(0, 1, 0, 1, 1, 3, 0, 8'h08, 0);
      set_lut(1, 2, 1, 3, 0, 3, 0, 8'h55, 1);
      do_load(TOT, TOT - 1, 1'b1, 1'b1);
      io = 4'b0011; nb = NN'($urandom);
      push(0, 1, "and_11");
      chk_out("and_11_model");
      tick();
      io = 4'b0001;
      push(0, 0, "and_01");
      run = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         push(0, tog_exp[k], "toggle");
         chk_out("toggle_model");
      end
      run = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         push(0, 2, "toggle_hold");
      end

      // framing errors: early tlast, then missing tlast (start of second load clears error)
      do_load(10, 9, 1'b0, 1'b1);
      push(0, 0, "early_tlast_out");
      do_load(TOT, -1, 1'b1, 1'b1);

      rand_cfg();
      do_load(TOT, TOT - 1, 1'b1, 1'b1);
      rand_run(40);

      // asynchronous reset in the middle of a load
      rand_cfg();
      do_load(40, -1, 1'b1, 1'b0);
      rst = 1'b1;
      chk_status(0, 0, 0, "async_rst");
      push(0, 0, "async_rst_out");
      tick();
      m_cfgd = 1'b0; m_ff = 0; m_running = 1'b0;
      rst = 1'b0;
      tick();
      chk_status(0, 0, 0, "after_rst");
      do_load(TOT, TOT - 1, 1'b1, 1'b1);
      rand_run(20);

      // out-of-range neighbour index reads 0; cfg ignored while running
      set_lut(0, 0, 200, 3, 1, 3, 0, 8'hAA, 0);
      set_lut(1, 0, 5, 3, 1, 3, 0, 8'hAA, 0);
      do_load(TOT, TOT - 1, 1'b0, 1'b1);
      nb = 8'hFF;
      push(0, 2, "oor_idx_ff");
      tick();
      nb = 8'h00;
      push(0, 0, "oor_idx_00");
      run = 1'b1;
      cfg = 1'b1;
      tick();
      chk_status(1, 0, 0, "cfg_in_run_a");
      tick();
      chk_status(1, 0, 0, "cfg_in_run_b");
      run = 1'b0;
      tick();
      chk_status(1, 0, 0, "run_drop");
      rand_cfg();
      do_load(TOT, TOT - 1, 1'b1, 1'b1);
      rand_run(20);

      repeat (2) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: actual %0d pending required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
